// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package imem_pkg;

    localparam int          IMEM_DEPTH_WORDS = 512;
    localparam logic [31:0] IMEM_NOP         = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READ,
        ST_RESP
    } imem_state_e;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response channels plus the sequential program-load port.
interface imem_fetch_responder_if #(
    parameter int AW = 9
);
    logic          load_start;
    logic          load_valid;
    logic [31:0]   load_data;
    logic          load_done;
    logic [AW:0]   load_count;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_ready;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instruction;
    logic          fetch_err;

    modport master (
        output load_start, load_valid, load_data, load_done,
        output fetch_req, fetch_addr, instr_ready,
        input  load_count, fetch_ready, instr_valid, instruction, fetch_err
    );

    modport slave (
        input  load_start, load_valid, load_data, load_done,
        input  fetch_req, fetch_addr, instr_ready,
        output load_count, fetch_ready, instr_valid, instruction, fetch_err
    );
endinterface

// File: rtl/imem_ram.sv
// Single-port instruction RAM: one write or one read per cycle, registered read data.
module imem_ram #(
    parameter int DEPTH_WORDS = 512,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    // Contents are deliberately never reset so a reloaded program can be partial.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: valid/ready fetch port plus sequential program loader.
// Optional IMEM_BOUNDS_CHECK_EN: misaligned/out-of-range fetches return NOP with fetch_err.
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input logic                   clk,
    input logic                   rst,
    imem_fetch_responder_if.slave bus
);
    imem_state_e   state_reg;
    logic          fetch_ready_reg;
    logic          instr_valid_reg;
    logic          fetch_err_reg;
    logic          addr_err_reg;
    logic [31:0]   instruction_reg;
    logic [AW:0]   count_reg;

    logic          accept;
    logic          addr_err;
    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    // A same-cycle load_start wins over a pending fetch.
    assign accept = (state_reg == ST_IDLE) && !bus.load_start && bus.fetch_req && fetch_ready_reg;

`ifdef IMEM_BOUNDS_CHECK_EN
    assign addr_err = (bus.fetch_addr[1:0] != 2'b00) ||
                      (bus.fetch_addr >= 32'(4 * DEPTH_WORDS));
`else
    assign addr_err = 1'b0;
`endif

    // count_reg doubles as the write pointer; its MSB marks a full memory.
    assign ram_we   = (state_reg == ST_LOAD) && bus.load_valid && !bus.load_start && !count_reg[AW];
    assign ram_re   = accept && !addr_err;
    assign ram_addr = ram_we ? count_reg[AW-1:0] : bus.fetch_addr[AW+1:2];

    imem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (bus.load_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            fetch_ready_reg <= 1'b0;
            instr_valid_reg <= 1'b0;
            fetch_err_reg   <= 1'b0;
            addr_err_reg    <= 1'b0;
            instruction_reg <= '0;
            count_reg       <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.load_start) begin
                        state_reg       <= ST_LOAD;
                        count_reg       <= '0;
                        fetch_ready_reg <= 1'b0;
                    end else if (accept) begin
                        state_reg       <= ST_READ;
                        addr_err_reg    <= addr_err;
                        fetch_ready_reg <= 1'b0;
                    end else begin
                        fetch_ready_reg <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (bus.load_start) begin
                        count_reg <= '0;
                    end else begin
                        if (ram_we) begin
                            count_reg <= count_reg + 1'b1;
                        end
                        if (bus.load_done) begin
                            state_reg       <= ST_IDLE;
                            fetch_ready_reg <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    instruction_reg <= addr_err_reg ? IMEM_NOP : ram_rdata;
                    fetch_err_reg   <= addr_err_reg;
                    instr_valid_reg <= 1'b1;
                    state_reg       <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.instr_ready) begin
                        instr_valid_reg <= 1'b0;
                        state_reg       <= ST_IDLE;
                        fetch_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.fetch_ready = fetch_ready_reg;
    assign bus.instr_valid = instr_valid_reg;
    assign bus.instruction = instruction_reg;
    assign bus.fetch_err   = fetch_err_reg;
    assign bus.load_count  = count_reg;
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Randomised scoreboard bench for imem_fetch_responder against an array-based memory model.
module tb_imem_fetch_responder;
    import imem_pkg::*;

    localparam int DEPTH = 512;
    localparam int AW    = 9;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_fetch_responder_if #(.AW(AW)) bus ();

    imem_fetch_responder #(.DEPTH_WORDS(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ref_mem [DEPTH];
    resp_t       exp_q [$];
    resp_t       mon_e;

    function automatic resp_t model(input logic [31:0] addr);
        resp_t r;
`ifdef IMEM_BOUNDS_CHECK_EN
        if ((addr % 4) != 0 || addr >= 32'(4 * DEPTH)) begin
            r.err  = 1'b1;
            r.data = 32'h0000_0013;
            return r;
        end
`endif
        r.err  = 1'b0;
        r.data = ref_mem[(addr / 4) % DEPTH];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response handshake pops the oldest expected response.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got %h with empty scoreboard", bus.instruction);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_instruction", 64'(bus.instruction), 64'(mon_e.data));
                check("resp_fetch_err", 64'(bus.fetch_err), 64'(mon_e.err));
                $display("resp instr=%h err=%b", bus.instruction, bus.fetch_err);
            end
        end
    end

    task automatic do_fetch(input logic [31:0] addr, input int hold);
        resp_t e;
        e = model(addr);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        for (int i = 0; i < 20 && bus.fetch_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        if (bus.fetch_ready !== 1'b1) begin
            check("fetch_ready_timeout", 64'(bus.fetch_ready), 64'd1);
            bus.fetch_req = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.fetch_req = 1'b0;
        exp_q.push_back(e);
        $display("fetch addr=%h exp=%h err=%b hold=%0d", addr, e.data, e.err, hold);
        check("valid_low_in_read", 64'(bus.instr_valid), 64'd0);
        check("ready_low_in_read", 64'(bus.fetch_ready), 64'd0);
        @(posedge clk); #1;
        check("valid_two_after_accept", 64'(bus.instr_valid), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(bus.instr_valid), 64'd1);
            check("hold_instruction", 64'(bus.instruction), 64'(e.data));
            check("hold_fetch_ready", 64'(bus.fetch_ready), 64'd0);
        end
        bus.instr_ready = 1'b1;
        @(posedge clk); #1;
        bus.instr_ready = 1'b0;
        check("valid_after_consume", 64'(bus.instr_valid), 64'd0);
        check("ready_after_consume", 64'(bus.fetch_ready), 64'd1);
    endtask

    task automatic do_load(input logic [31:0] words[$], input bit done_with_last,
                           input bit hold_fetch, input logic [31:0] hold_addr);
        int n;
        n = words.size();
        bus.load_start = 1'b1;
        if (hold_fetch) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = hold_addr;
        end
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        check("load_count_cleared", 64'(bus.load_count), 64'd0);
        check("ready_low_in_load", 64'(bus.fetch_ready), 64'd0);
        for (int i = 0; i < n; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = words[i];
            if (i < DEPTH) ref_mem[i] = words[i];
            if (done_with_last && i == n - 1) bus.load_done = 1'b1;
            @(posedge clk); #1;
            bus.load_valid = 1'b0;
            bus.load_done  = 1'b0;
            if (hold_fetch && !(done_with_last && i == n - 1))
                check("held_fetch_not_ready", 64'(bus.fetch_ready), 64'd0);
        end
        if (!done_with_last) begin
            check("load_count_pre_done", 64'(bus.load_count), 64'(n < DEPTH ? n : DEPTH));
            bus.load_done = 1'b1;
            @(posedge clk); #1;
            bus.load_done = 1'b0;
        end
        check("load_count", 64'(bus.load_count), 64'(n < DEPTH ? n : DEPTH));
        check("ready_after_done", 64'(bus.fetch_ready), 64'd1);
        $display("load words=%0d count=%0d", n, bus.load_count);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fetch_ready"}, 64'(bus.fetch_ready), 64'd0);
        check({tag, "_instr_valid"}, 64'(bus.instr_valid), 64'd0);
        check({tag, "_instruction"}, 64'(bus.instruction), 64'd0);
        check({tag, "_fetch_err"}, 64'(bus.fetch_err), 64'd0);
        check({tag, "_load_count"}, 64'(bus.load_count), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w [$];
        logic [31:0] addr;
        int          acc;

        rst = 1'b1;
        bus.load_start = 0; bus.load_valid = 0; bus.load_data = 0; bus.load_done = 0;
        bus.fetch_req = 0; bus.fetch_addr = 0; bus.instr_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        rst = 1'b0;
        #1;
        check("ready_before_first_edge", 64'(bus.fetch_ready), 64'd0);
        @(posedge clk); #1;
        check("ready_first_idle", 64'(bus.fetch_ready), 64'd1);

        // Directed two-word program.
        w = '{32'h0226_8193, 32'h0C60_0E93};
        do_load(w, 1'b0, 1'b0, 32'h0);
        do_fetch(32'h0, 0);
        do_fetch(32'h4, 0);

        // Fill the whole memory, then overfill to exercise saturation.
        w.delete();
        for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
        do_load(w, 1'b1, 1'b0, 32'h0);
        w.delete();
        for (int i = 0; i < DEPTH + 3; i++) w.push_back($urandom);
        do_load(w, 1'b1, 1'b0, 32'h0);
        do_fetch(32'(4 * (DEPTH - 1)), 0);
        do_fetch(32'h0, 0);

        // Fetch held across a load returns the last word written.
        w = '{$urandom, $urandom, $urandom};
        do_load(w, 1'b0, 1'b1, 32'h8);
        do_fetch(32'h8, 0);

        do_fetch(32'h10, 5);
        do_fetch(32'h2, 0);
        do_fetch(32'h800, 1);

        // Random mix of loads and fetches.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                w.delete();
                for (int i = 0; i < int'($urandom_range(1, 12)); i++) w.push_back($urandom);
                do_load(w, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
            end else begin
                if ($urandom_range(0, 2) == 0) addr = $urandom;
                else addr = 32'(4 * $urandom_range(0, DEPTH - 1));
                do_fetch(addr, int'($urandom_range(0, 3)));
            end
        end

        // Back-to-back with instr_ready tied high: one accept every 3 cycles.
        addr = 32'(4 * $urandom_range(0, DEPTH - 1));
        acc = 0;
        bus.instr_ready = 1'b1;
        bus.fetch_addr  = addr;
        bus.fetch_req   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 11) begin
                bus.fetch_req = 1'b0;
            end else if (bus.fetch_ready === 1'b1) begin
                exp_q.push_back(model(addr));
                acc++;
            end
        end
        check("throughput_accepts", 64'(acc), 64'd4);
        repeat (4) @(posedge clk);
        #1;
        bus.instr_ready = 1'b0;
        check("throughput_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a fetch discards the response.
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
        @(posedge clk); #1;
        bus.fetch_req = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_fetch_rst");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_fetch_rst", 64'(bus.fetch_ready), 64'd1);

        // Reset mid-load: written words persist, pointer restarts.
        bus.load_start = 1'b1;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = $urandom;
            ref_mem[i]     = bus.load_data;
            @(posedge clk); #1;
        end
        bus.load_valid = 1'b0;
        check("count_before_rst", 64'(bus.load_count), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        check("count_cleared_by_rst", 64'(bus.load_count), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        w = '{$urandom};
        do_load(w, 1'b1, 1'b0, 32'h0);
        do_fetch(32'h0, 0);
        do_fetch(32'h4, 0);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
